// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chess_pkg
//  Description : Shared types and default constants for the chess turn
//                controller: FSM state encoding and parameter defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package chess_pkg;

    // 10 ms at 50 MHz
    localparam int C_DEBOUNCE_CYCLES_DEFAULT = 500000;
    // Ply counter width
    localparam int C_MOVE_W_DEFAULT          = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WHITE_RUN = 3'd1,
        S_BLACK_RUN = 3'd2,
        S_PAUSED    = 3'd3,
        S_OVER      = 3'd4
    } state_e;

endpackage : chess_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Raw pushbutton conditioning: 2-flop synchroniser, counting
//                debouncer and rising-edge detector producing a single-cycle
//                press pulse.
//  Ports       : clk     - system clock
//                reset   - asynchronous active-high reset
//                btn_i   - raw asynchronous button (active high)
//                press_o - one-cycle pulse on each accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       fill_q;
    logic             level_q,  level_d;
    logic             prev_q;
    logic             block_q,  block_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             w_target;

    // While blocked, the button is presumed held from before reset. The
    // debouncer then waits for a stable low before any press may register, so
    // a button held through reset release yields no pulse until re-pressed.
    assign w_target = block_q | level_q;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        block_d = block_q;
        if (!fill_q[1]) begin
            // Synchroniser still holds reset values; do not count them.
            cnt_d = '0;
        end else if (sync2_q == w_target) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (block_q) begin
                block_d = 1'b0;
            end else begin
                level_d = sync2_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            block_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            level_q <= level_d;
            prev_q  <= level_q;
            block_q <= block_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = level_q & ~prev_q;

endmodule : button_debounce
`default_nettype wire

// File: rtl/chess_turn_controller.sv
`default_nettype none
// ============================================================================
//  Module      : chess_turn_controller
//  Description : Chess clock turn controller. Conditions four pushbuttons and
//                sequences IDLE / WHITE_RUN / BLACK_RUN / PAUSED / OVER,
//                driving the run flags of two countdown timers.
//  Ports       : clk, reset             - clock, async active-high reset
//                btn_start/white/black/pause - raw pushbuttons
//                timeout_white/black    - timer expired levels
//                flag_white/black       - timer run(1)/pause(0)
//                white_to_move          - side to move
//                game_over, winner_white - end of game and result
//                move_count             - completed plies (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module chess_turn_controller
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT,
    parameter int MOVE_W          = C_MOVE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_white,
    input  logic              btn_black,
    input  logic              btn_pause,
    input  logic              timeout_white,
    input  logic              timeout_black,
    output logic              flag_white,
    output logic              flag_black,
    output logic              white_to_move,
    output logic              game_over,
    output logic              winner_white,
    output logic [MOVE_W-1:0] move_count
);

    // Button index within the raw/press vectors
    localparam int C_IDX_START = 0;
    localparam int C_IDX_WHITE = 1;
    localparam int C_IDX_BLACK = 2;
    localparam int C_IDX_PAUSE = 3;

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {btn_pause, btn_black, btn_white, btn_start};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_raw[gi]),
            .press_o (press[gi])
        );
    end

    logic start_p, white_p, black_p, pause_p;
    assign start_p = press[C_IDX_START];
    assign white_p = press[C_IDX_WHITE];
    assign black_p = press[C_IDX_BLACK];
    assign pause_p = press[C_IDX_PAUSE];

    state_e            state_q,  state_d;
    logic              wtm_q,    wtm_d;
    logic              winner_q, winner_d;
    logic [MOVE_W-1:0] moves_q,  moves_d;
    logic [MOVE_W-1:0] moves_inc;
    logic              flag_white_q;
    logic              flag_black_q;

    // Ply counter holds at all-ones once reached
    assign moves_inc = (moves_q == {MOVE_W{1'b1}}) ? moves_q : moves_q + MOVE_W'(1);

    // Each branch is an if/else-if chain in priority order
    // (timeout > own-side move > pause), so a losing event is simply dropped.
    always_comb begin
        state_d  = state_q;
        wtm_d    = wtm_q;
        winner_d = winner_q;
        moves_d  = moves_q;
        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    state_d = S_WHITE_RUN;
                end
            end
            S_WHITE_RUN: begin
                if (timeout_white) begin
                    state_d  = S_OVER;
                    winner_d = 1'b0;
                end else if (white_p) begin
                    state_d = S_BLACK_RUN;
                    moves_d = moves_inc;
                    wtm_d   = 1'b0;
                end else if (pause_p) begin
                    state_d = S_PAUSED;
                end
            end
            S_BLACK_RUN: begin
                if (timeout_black) begin
                    state_d  = S_OVER;
                    winner_d = 1'b1;
                end else if (black_p) begin
                    state_d = S_WHITE_RUN;
                    moves_d = moves_inc;
                    wtm_d   = 1'b1;
                end else if (pause_p) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (pause_p || start_p) begin
                    state_d = wtm_q ? S_WHITE_RUN : S_BLACK_RUN;
                end
            end
            S_OVER: begin
                if (start_p) begin
                    state_d  = S_IDLE;
                    moves_d  = '0;
                    winner_d = 1'b0;
                    wtm_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wtm_q        <= 1'b1;
            winner_q     <= 1'b0;
            moves_q      <= '0;
            flag_white_q <= 1'b0;
            flag_black_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wtm_q        <= wtm_d;
            winner_q     <= winner_d;
            moves_q      <= moves_d;
            // Flags registered from the next state so they track the state
            // register exactly and are glitch-free to the timers.
            flag_white_q <= (state_d == S_WHITE_RUN);
            flag_black_q <= (state_d == S_BLACK_RUN);
        end
    end

    assign flag_white    = flag_white_q;
    assign flag_black    = flag_black_q;
    assign white_to_move = wtm_q;
    assign game_over     = (state_q == S_OVER);
    assign winner_white  = winner_q;
    assign move_count    = moves_q;

endmodule : chess_turn_controller
`default_nettype wire

// File: tb/tb_chess_turn_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chess_turn_controller
//  Description : Self-checking bench for chess_turn_controller with
//                DEBOUNCE_CYCLES=4. Two instances share stimulus: one with an
//                8-bit ply counter and one with a 2-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chess_turn_controller;

    localparam int D = 4;

    // Button mask bits: [0]=start [1]=white [2]=black [3]=pause
    localparam logic [3:0] B_N = 4'b0000;
    localparam logic [3:0] B_S = 4'b0001;
    localparam logic [3:0] B_W = 4'b0010;
    localparam logic [3:0] B_B = 4'b0100;
    localparam logic [3:0] B_P = 4'b1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_start = 1'b0, btn_white = 1'b0, btn_black = 1'b0, btn_pause = 1'b0;
    logic timeout_white = 1'b0, timeout_black = 1'b0;

    logic       fw8, fb8, wtm8, over8, win8;
    logic [7:0] cnt8;
    logic       fw2, fb2, wtm2, over2, win2;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    chess_turn_controller #(.DEBOUNCE_CYCLES(D), .MOVE_W(8)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_white(btn_white),
        .btn_black(btn_black), .btn_pause(btn_pause),
        .timeout_white(timeout_white), .timeout_black(timeout_black),
        .flag_white(fw8), .flag_black(fb8), .white_to_move(wtm8),
        .game_over(over8), .winner_white(win8), .move_count(cnt8)
    );

    chess_turn_controller #(.DEBOUNCE_CYCLES(D), .MOVE_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_white(btn_white),
        .btn_black(btn_black), .btn_pause(btn_pause),
        .timeout_white(timeout_white), .timeout_black(timeout_black),
        .flag_white(fw2), .flag_black(fb2), .white_to_move(wtm2),
        .game_over(over2), .winner_white(win2), .move_count(cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] btn;
        logic       to_w;
        logic       to_b;
        logic [4:0] exp;    // {flag_white, flag_black, white_to_move, game_over, winner_white}
        int         cnt;    // expected plies (unsaturated)
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [3:0] b, logic tw, logic tb, logic [4:0] e, int c);
        vec_t v;
        v.btn = b; v.to_w = tw; v.to_b = tb; v.exp = e; v.cnt = c;
        return v;
    endfunction

    function automatic logic [15:0] obs8();
        return {3'b000, fw8, fb8, wtm8, over8, win8, cnt8};
    endfunction

    function automatic logic [15:0] obs2();
        return {9'b0, fw2, fb2, wtm2, over2, win2, cnt2};
    endfunction

    function automatic logic [15:0] exp8(logic [4:0] e, int c);
        return {3'b000, e, c[7:0]};
    endfunction

    function automatic logic [15:0] exp2(logic [4:0] e, int c);
        int s;
        s = (c > 3) ? 3 : c;
        return {9'b0, e, s[1:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [4:0] e, input int c);
        check({name, "_w8"}, obs8(), exp8(e, c));
        check({name, "_w2"}, obs2(), exp2(e, c));
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_pause, btn_black, btn_white, btn_start} = m;
    endtask

    // Called on a falling edge; hold, release, and let the release debounce
    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        repeat (hold) @(negedge clk);
        set_btns(B_N);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            btn        tw    tb    {fw,fb,wtm,ov,win} cnt
        vecs[0]  = mk(B_N,       1'b0, 1'b0, 5'b00100, 0); // reset state
        vecs[1]  = mk(B_S,       1'b0, 1'b0, 5'b10100, 0); // start
        vecs[2]  = mk(B_B,       1'b0, 1'b0, 5'b10100, 0); // black ignored
        vecs[3]  = mk(B_S,       1'b0, 1'b0, 5'b10100, 0); // start ignored
        vecs[4]  = mk(B_N,       1'b0, 1'b1, 5'b10100, 0); // other-side timeout
        vecs[5]  = mk(B_W,       1'b0, 1'b0, 5'b01000, 1);
        vecs[6]  = mk(B_B,       1'b0, 1'b0, 5'b10100, 2);
        vecs[7]  = mk(B_W,       1'b0, 1'b0, 5'b01000, 3);
        vecs[8]  = mk(B_P,       1'b0, 1'b0, 5'b00000, 3); // paused
        vecs[9]  = mk(B_N,       1'b0, 1'b1, 5'b00000, 3); // timeout while paused
        vecs[10] = mk(B_P,       1'b0, 1'b0, 5'b01000, 3); // resume black
        vecs[11] = mk(B_B,       1'b0, 1'b0, 5'b10100, 4);
        vecs[12] = mk(B_P,       1'b0, 1'b0, 5'b00100, 4);
        vecs[13] = mk(B_S,       1'b0, 1'b0, 5'b10100, 4); // start also resumes
        vecs[14] = mk(B_W | B_P, 1'b0, 1'b0, 5'b01000, 5); // move beats pause
        vecs[15] = mk(B_N,       1'b1, 1'b0, 5'b01000, 5); // other-side timeout
        vecs[16] = mk(B_N,       1'b0, 1'b1, 5'b00011, 5); // black flags, white wins
        vecs[17] = mk(B_W,       1'b0, 1'b0, 5'b00011, 5); // ignored in OVER
        vecs[18] = mk(B_S,       1'b0, 1'b0, 5'b00100, 0); // back to IDLE
        vecs[19] = mk(B_W,       1'b0, 1'b0, 5'b00100, 0); // ignored in IDLE

        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].btn != B_N) begin
                press(vecs[i].btn, 10);
            end else if (vecs[i].to_w || vecs[i].to_b) begin
                timeout_white = vecs[i].to_w;
                timeout_black = vecs[i].to_b;
                repeat (2) @(negedge clk);
                timeout_white = 1'b0;
                timeout_black = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (2) @(negedge clk);
            end
            check_both($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cnt);
        end

        // Start latency: pulse lands on edge D+3 after the raw press
        do_reset();
        check_both("reset_state", 5'b00100, 0);
        btn_start = 1'b1;
        repeat (D + 2) @(negedge clk);
        check("start_not_yet", {15'b0, fw8}, 16'h0000);
        @(negedge clk);
        check_both("start_latency", 5'b10100, 0);
        repeat (10) @(negedge clk);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        check_both("start_held", 5'b10100, 0);

        // White pulse and white timeout in the same cycle: timeout wins
        btn_white = 1'b1;
        repeat (D + 2) @(negedge clk);
        timeout_white = 1'b1;
        @(negedge clk);
        timeout_white = 1'b0;
        check_both("timeout_vs_move", 5'b00110, 0);
        repeat (10) @(negedge clk);
        btn_white = 1'b0;
        repeat (10) @(negedge clk);
        check_both("over_stays", 5'b00110, 0);

        // Short glitches rejected, long hold gives exactly one move
        do_reset();
        press(B_S, 10);
        for (int g = 0; g < 3; g++) begin
            btn_white = 1'b1;
            repeat (3) @(negedge clk);
            btn_white = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_both("glitch_reject", 5'b10100, 0);
        btn_white = 1'b1;
        repeat (20) @(negedge clk);
        check_both("long_hold", 5'b01000, 1);
        btn_white = 1'b0;
        repeat (10) @(negedge clk);
        check_both("long_release", 5'b01000, 1);

        // Asynchronous reset mid-BLACK_RUN with start held across release
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_both("async_reset", 5'b00100, 0);
        btn_start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_both("held_thru_reset", 5'b00100, 0);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        press(B_S, 10);
        check_both("repress_after_reset", 5'b10100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_chess_turn_controller
`default_nettype wire

// File: doc/chess_turn_controller.md
CHESS_TURN_CONTROLLER -- requirements
Module: chess_turn_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning cycles a synchronised button must hold a new level before it is accepted (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter MOVE_W, default 8, meaning the width of the ply counter.
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have ports btn_start, btn_white, btn_black and btn_pause  input  1 each  meaning raw, asynchronous, active-high pushbuttons.
REQ-006 The block SHALL have ports timeout_white and timeout_black  input  1 each  meaning level-high "time expired" from the white and black countdown timers.
REQ-007 The block SHALL have ports flag_white and flag_black  output  1 each  meaning run(1)/pause(0) to the white and black countdown timer flag inputs.
REQ-008 The block SHALL have ports white_to_move, game_over and winner_white  output  1 each  meaning side to move, game ended, and white won (valid only while game_over).
REQ-009 The block SHALL have port move_count  output  MOVE_W  meaning completed plies.

Function
REQ-010 Each button SHALL pass a 2-flop synchroniser, then a debouncer that changes its level only after DEBOUNCE_CYCLES consecutive equal samples, then a rising-edge detector giving a 1-cycle press pulse.
REQ-011 A press pulse SHALL occur no later than DEBOUNCE_CYCLES+3 cycles after the raw input goes and stays high; bounces shorter than DEBOUNCE_CYCLES SHALL give no pulse; holding SHALL give exactly one pulse.
REQ-012 The FSM SHALL have states IDLE, WHITE_RUN, BLACK_RUN, PAUSED and OVER.
REQ-013 IDLE: start press -> WHITE_RUN; all other inputs ignored.
REQ-014 WHITE_RUN: timeout_white -> OVER with winner_white=0; else white press -> BLACK_RUN with move_count+1; else pause press -> PAUSED; black and start presses ignored.
REQ-015 BLACK_RUN SHALL mirror REQ-014: timeout_black -> OVER with winner_white=1; black press -> WHITE_RUN with move_count+1; pause -> PAUSED.
REQ-016 Same-cycle priority SHALL be timeout > own-side move > pause; a lower-priority event in that cycle SHALL be discarded, not deferred.
REQ-017 PAUSED: pause or start press SHALL return to the side held in white_to_move; timeouts ignored.
REQ-018 OVER: start press -> IDLE, clearing move_count and winner_white and setting white_to_move=1.
REQ-019 Timeout from the side not running SHALL be ignored in every state.
REQ-020 flag_white SHALL be 1 exactly in WHITE_RUN; flag_black exactly in BLACK_RUN; never both 1; both registered, changing the cycle after the causing pulse.
REQ-021 game_over SHALL be 1 exactly in OVER; white_to_move SHALL toggle only on an accepted move.
REQ-022 move_count SHALL saturate at 2^MOVE_W-1 while play continues.

Reset
REQ-023 On reset: state IDLE, all flags 0, game_over=0, winner_white=0, white_to_move=1, move_count=0, debouncer levels 0, counters 0.
REQ-024 Reset mid-game SHALL take effect immediately; a button held through reset release SHALL give no pulse until released and pressed again.

Structure
REQ-025 Package chess_pkg SHALL hold the FSM state enum and default constants for DEBOUNCE_CYCLES and MOVE_W.
REQ-026 Sub-module button_debounce (synchroniser, debouncer, edge detector, press-pulse output) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset, start press -> flag_white=1 within 7 cycles, flag_black=0, move_count=0.
REQ-028 In WHITE_RUN, white press then black press -> flag_black, then flag_white, move_count=2, white_to_move=1.
REQ-029 3-cycle glitches on btn_white -> no state change; 20-cycle hold -> exactly one move.
REQ-030 Same-cycle white pulse and timeout_white in WHITE_RUN -> OVER, winner_white=0, move_count unchanged, both flags 0.
REQ-031 BLACK_RUN, pause, pause -> flags 0 while paused, then flag_black=1; timeout_black while PAUSED ignored.
REQ-032 MOVE_W=2, five moves -> move_count=3; reset mid-BLACK_RUN -> IDLE, all outputs at reset values.
